// File: rtl/rv32i_types.sv
// ============================================================================
// Module      : rv32i_types (package)
// Description : Shared integer-pipeline types: register index and the
//               {dest, data} writeback request carried to the regfile port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

    typedef logic [4:0] regidx_t;

    typedef struct packed {
        regidx_t     dest;
        logic [31:0] data;
    } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/wb_skid_fifo.sv
// ============================================================================
// Module      : wb_skid_fifo
// Description : DEPTH-entry FIFO of writeback requests holding out-of-order
//               muldiv results until the regfile write port is free.
// Ports       : clk, rst (sync, active-low)
//               push/push_data  - enqueue (ignored when full)
//               pop             - dequeue head (ignored when empty)
//               head            - current head entry (valid when !empty)
//               full/empty      - occupancy flags, from registered pointers only
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_skid_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    wb_req_t        r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when indices match.
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Single regfile write-port arbiter and long-latency scoreboard.
//               In-order WB writes own the port; buffered muldiv results use
//               free slots. Pending destinations raise hazard for decode.
// Ports       : clk, rst (sync, active-low)
//               wb_valid/wb_dest/wb_data      - pipeline writeback
//               md_valid/md_ready/md_dest/md_data - muldiv result handshake
//               iss_valid/iss_ready/iss_dest  - long-latency issue from decode
//               src_a/src_b/dst_q, hazard     - decode hazard query
//               pipe_stall                    - one-cycle WB freeze on starvation
//               rf_load/rf_dest/rf_data       - regfile write port
// Config      : REGFILE_ARB_STARVE_EN - enables the starvation counter and
//               pipe_stall; when undefined pipe_stall is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
    import rv32i_types::*;
#(
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_data,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_dest,
    input  logic [31:0] md_data,
    input  logic        iss_valid,
    input  logic [4:0]  iss_dest,
    output logic        iss_ready,
    input  logic [4:0]  src_a,
    input  logic [4:0]  src_b,
    input  logic [4:0]  dst_q,
    output logic        hazard,
    output logic        pipe_stall,
    output logic        rf_load,
    output logic [4:0]  rf_dest,
    output logic [31:0] rf_data
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (MAX_OUTSTANDING < 1 || STARVE_LIMIT < 1) begin : g_bad_limits
        $error("MAX_OUTSTANDING and STARVE_LIMIT must be at least 1");
    end

    wb_req_t        w_head;
    wb_req_t        w_push_req;
    logic           w_full;
    logic           w_empty;
    logic           w_wb_own;
    logic           w_pop;
    logic           w_iss;
    logic [31:0]    r_pending;
    logic [31:0]    w_pending_nxt;
    logic [CW-1:0]  r_count;

    assign w_push_req = '{dest: md_dest, data: md_data};

    wb_skid_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (md_valid),
        .push_data (w_push_req),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Full is checked against registered state only, so a same-cycle pop
    // never frees a slot for a push (no bypass, no md_valid->md_ready path).
    assign md_ready  = !w_full;
    assign iss_ready = (r_count < CW'(MAX_OUTSTANDING));
    assign w_iss     = iss_valid && iss_ready;

    // Writes to x0 from the pipeline do not claim the port.
    assign w_wb_own  = wb_valid && (wb_dest != 5'd0) && !pipe_stall;
    assign w_pop     = !w_wb_own && !w_empty;

    always_comb begin
        rf_load = 1'b0;
        rf_dest = 5'd0;
        rf_data = 32'd0;
        if (w_wb_own) begin
            rf_load = 1'b1;
            rf_dest = wb_dest;
            rf_data = wb_data;
        end else if (!w_empty) begin
            rf_load = (w_head.dest != 5'd0);
            rf_dest = w_head.dest;
            rf_data = w_head.data;
        end
    end

    // Clear first, then set: a same-edge issue to the retiring index wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop) begin
            w_pending_nxt[w_head.dest] = 1'b0;
        end
        if (w_iss) begin
            w_pending_nxt[iss_dest] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pending <= '0;
            r_count   <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            // x0 issues still occupy an outstanding slot until their pop.
            if (w_iss && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_iss && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign hazard = r_pending[src_a] | r_pending[src_b] | r_pending[dst_q];

`ifdef REGFILE_ARB_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] r_starve;

    // Counter holds the number of completed waiting cycles, so the stall
    // lands on the STARVE_LIMIT-th waiting cycle and forces the pop there.
    assign pipe_stall = !w_empty && (r_starve == SW'(STARVE_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (w_pop) begin
            r_starve <= '0;
        end else if (!w_empty) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`else
    assign pipe_stall = 1'b0;
`endif

endmodule

`default_nettype wire
